// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: encodings shared by the branch-target builder and the pc sequencer
package pc_sequencer_pkg;
  typedef enum logic [1:0] {
    FB_NONE   = 2'b00,
    FB_JAL    = 2'b01,
    FB_JALR   = 2'b10,
    FB_BRANCH = 2'b11
  } flag_branch_e;
  typedef enum logic [2:0] {
    IT_R = 3'd0,
    IT_I = 3'd1,
    IT_S = 3'd2,
    IT_B = 3'd3,
    IT_U = 3'd4,
    IT_J = 3'd5
  } instr_type_e;
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_TRAP  = 2'd3
  } seq_state_e;
  localparam int CNT_W = 3;
endpackage

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch pc, resolves taken redirects, flushes younger stages, traps on misaligned targets
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_target,
  input  logic [1:0]  flag_branch,
  input  logic        branch_cond,
  input  logic        redirect_valid,
  input  logic        stall,
  input  logic        fetch_ready,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        flush,
  output logic        misaligned,
  output logic [31:0] bad_addr
);
  seq_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             taken;
  logic             adv;
  logic [31:0]      eff;
  always_comb begin
    taken = redirect_valid && (flag_branch == FB_JAL || flag_branch == FB_JALR ||
                               (flag_branch == FB_BRANCH && branch_cond));
    eff   = flag_branch == FB_JALR ? {pc_target[31:1], 1'b0} : pc_target;
    adv   = fetch_valid && fetch_ready && !stall;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      pc          <= RESET_VECTOR;
      cnt         <= '0;
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
      misaligned  <= 1'b0;
      bad_addr    <= '0;
    end else begin
      case (state)
        ST_BOOT: begin
          state       <= ST_RUN;
          fetch_valid <= 1'b1;
        end
        ST_RUN: begin
          if (taken && eff[1:0] == 2'b00) begin
            pc    <= eff;
            cnt   <= CNT_W'(FLUSH_CYCLES);
            flush <= 1'b1;
            state <= ST_FLUSH;
          end else if (taken) begin
            // any non-word-aligned target traps; pc keeps the last good address
            state       <= ST_TRAP;
            misaligned  <= 1'b1;
            bad_addr    <= eff;
            fetch_valid <= 1'b0;
            flush       <= 1'b1;
          end else if (adv) begin
            pc <= pc + 32'd4;
          end
        end
        ST_FLUSH: begin
          if (adv) pc <= pc + 32'd4;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= ST_RUN;
            flush <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors with hand-computed pc/flush/trap expectations
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_target;
  logic [1:0]  flag_branch;
  logic        branch_cond;
  logic        redirect_valid;
  logic        stall;
  logic        fetch_ready;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush;
  logic        misaligned;
  logic [31:0] bad_addr;
  int errors = 0;
  int checks = 0;
  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .pc_target(pc_target), .flag_branch(flag_branch),
    .branch_cond(branch_cond), .redirect_valid(redirect_valid), .stall(stall),
    .fetch_ready(fetch_ready), .pc(pc), .fetch_valid(fetch_valid), .flush(flush),
    .misaligned(misaligned), .bad_addr(bad_addr)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic redir(input logic [1:0] f, input logic [31:0] t, input logic c);
    flag_branch = f;
    pc_target = t;
    branch_cond = c;
    redirect_valid = 1'b1;
  endtask
  task automatic pf(input string tag, input logic [31:0] p, input logic fl);
    check({tag, "_pc"}, pc, p);
    check({tag, "_flush"}, {31'd0, flush}, {31'd0, fl});
  endtask
  initial begin
    rst_n = 1'b0; fetch_ready = 1'b1; stall = 1'b0;
    pc_target = '0; flag_branch = 2'b00; branch_cond = 1'b0; redirect_valid = 1'b0;
    step(); step();
    check("rst_pc", pc, 32'h0);
    check("rst_fv", {31'd0, fetch_valid}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_mis", {31'd0, misaligned}, 32'd0);
    check("rst_bad", bad_addr, 32'h0);
    rst_n = 1'b1;
    step();
    check("run_fv", {31'd0, fetch_valid}, 32'd1);
    pf("seq0", 32'h0, 1'b0);
    step(); pf("seq1", 32'h4, 1'b0);
    step(); pf("seq2", 32'h8, 1'b0);
    step(); step(); pf("seq4", 32'h10, 1'b0);
    redir(2'b01, 32'h100, 1'b0);
    step(); pf("jal0", 32'h100, 1'b1);
    redirect_valid = 1'b0;
    step(); pf("jal1", 32'h104, 1'b1);
    step(); pf("jal2", 32'h108, 1'b0);
    redir(2'b11, 32'h40, 1'b0);
    step(); pf("bnt", 32'h10C, 1'b0);
    branch_cond = 1'b1;
    step(); pf("bt0", 32'h40, 1'b1);
    redirect_valid = 1'b0;
    step(); pf("bt1", 32'h44, 1'b1);
    step(); pf("bt2", 32'h48, 1'b0);
    stall = 1'b1;
    redir(2'b01, 32'h80, 1'b0);
    step(); pf("stjal", 32'h80, 1'b1);
    stall = 1'b0;
    redir(2'b01, 32'h300, 1'b0);
    step(); pf("ign1", 32'h84, 1'b1);
    step(); pf("ign2", 32'h88, 1'b0);
    redirect_valid = 1'b0;
    stall = 1'b1;
    step(); pf("stall", 32'h88, 1'b0);
    stall = 1'b0;
    redir(2'b01, 32'hFFFF_FFFC, 1'b0);
    step(); pf("wrap0", 32'hFFFF_FFFC, 1'b1);
    redirect_valid = 1'b0;
    step(); pf("wrap1", 32'h0, 1'b1);
    step(); pf("wrap2", 32'h4, 1'b0);
    fetch_ready = 1'b0;
    step(); pf("nordy", 32'h4, 1'b0);
    fetch_ready = 1'b1;
    redir(2'b10, 32'h201, 1'b0);
    step(); pf("jalr", 32'h200, 1'b1);
    check("jalr_mis", {31'd0, misaligned}, 32'd0);
    redirect_valid = 1'b0;
    step(); step(); pf("jalr2", 32'h208, 1'b0);
    redir(2'b10, 32'h202, 1'b0);
    step();
    check("trap_mis", {31'd0, misaligned}, 32'd1);
    check("trap_bad", bad_addr, 32'h202);
    check("trap_fv", {31'd0, fetch_valid}, 32'd0);
    pf("trap", 32'h208, 1'b1);
    redir(2'b01, 32'h400, 1'b0);
    step(); step(); pf("trap_hold", 32'h208, 1'b1);
    check("trap_hold_mis", {31'd0, misaligned}, 32'd1);
    redirect_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_trap_mis", {31'd0, misaligned}, 32'd0);
    check("arst_trap_bad", bad_addr, 32'h0);
    pf("arst_trap", 32'h0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    redir(2'b01, 32'h100, 1'b0);
    step(); pf("rjal", 32'h100, 1'b1);
    redirect_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    pf("arst_flush", 32'h0, 1'b0);
    check("arst_fv", {31'd0, fetch_valid}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Consumer end of the branch-target interface. Takes pc_target/flag_branch from the execute-stage target builder plus the ALU compare result, and decides taken/not-taken.
- Owns the architectural fetch PC and drives the instruction-memory fetch handshake.
- On a taken redirect, loads the target and flushes younger pipeline stages for a fixed number of cycles.
- Traps and halts on a misaligned target.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, cycles flush stays high after a taken redirect; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- pc_target  in  32  redirect target from target builder.
- flag_branch  in  2  00 none, 01 jal, 10 jalr, 11 conditional branch.
- branch_cond  in  1  ALU compare result; used only when flag_branch=11.
- redirect_valid  in  1  execute-stage instruction is valid (not a bubble).
- stall  in  1  hazard stall; freezes sequential PC advance.
- fetch_ready  in  1  instruction memory accepts the current pc.
- pc  out  32  current fetch address.
- fetch_valid  out  1  pc is a valid fetch request.
- flush  out  1  squash IF/ID/EX-younger instructions.
- misaligned  out  1  sticky trap flag.
- bad_addr  out  32  offending target, latched on trap.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_VECTOR, fetch_valid=0, flush=0, misaligned=0, bad_addr=0, flush counter=0, state=BOOT. Applies immediately, including mid-flush or mid-trap.
- States: BOOT, RUN, FLUSH, TRAP.
- BOOT: fetch_valid=0. Goes to RUN after one clock.
- Effective target: for jalr, pc_target with bit0 cleared; otherwise pc_target unchanged.
- Taken: redirect_valid=1 and (flag_branch=01, or 10, or (11 and branch_cond=1)). flag 00, or 11 with branch_cond=0, is not taken: no flush, normal advance.
- RUN, taken, effective target[1:0]=00:
  - At the edge: pc <= target, flush counter <= FLUSH_CYCLES, state <= FLUSH.
  - Result: flush is high starting the cycle after the sampling edge, for exactly FLUSH_CYCLES cycles.
- RUN, taken, target[1]=1:
  - At the edge: state <= TRAP, misaligned <= 1, bad_addr <= effective target; pc unchanged.
- RUN, not taken: if fetch_valid && fetch_ready && !stall, then pc <= pc+4. Otherwise pc holds.
- FLUSH:
  - fetch_valid=1 and flush=1; pc advances under the same fetch_ready/stall rule.
  - redirect_valid is ignored, because the instruction is being squashed.
  - Counter decrements each cycle; when it reaches 1, next state is RUN and flush drops.
- TRAP: fetch_valid=0, flush=1, pc frozen, all inputs ignored. Exit only via rst_n.
- Priority in RUN: taken redirect > stall > sequential advance. On a redirect + fetch handshake in the same cycle, the increment is discarded and the target wins.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC -> 32'h0000_0000 with no trap. Target add is done upstream and is not re-checked for overflow.
- All outputs are registered or decoded purely from state. No combinational path from inputs to pc or fetch_valid.
- Counter width is 3 bits.

Decomposition:
- Shared package:
  - flag_branch encodings: FB_NONE=2'b00, FB_JAL=2'b01, FB_JALR=2'b10, FB_BRANCH=2'b11.
  - instr_type codes: R=0, I=1, S=2, B=3, U=4, J=5.
  - State encoding for BOOT/RUN/FLUSH/TRAP.
- Keep these shared with the target builder so the encodings cannot drift.
- No sub-module; the taken-decode and flush counter stay inline.

Test Plan:
- Reset then release, fetch_ready=1, stall=0 -> cycle 1 fetch_valid=0; then pc = 0x0, 0x4, 0x8 on successive cycles.
- At pc=0x10: flag_branch=01, pc_target=0x100, redirect_valid=1 -> next cycle pc=0x100, flush high 2 cycles, then pc=0x104, 0x108, flush=0.
- flag_branch=11, pc_target=0x40: branch_cond=0 -> no flush, pc+4. branch_cond=1 -> pc=0x40, flush 2 cycles.
- flag_branch=10, pc_target=0x201 -> pc=0x200, no trap. pc_target=0x202 -> misaligned=1, bad_addr=0x202, fetch_valid=0, pc frozen until rst_n.
- stall=1 with a taken jal to 0x80 in the same cycle -> pc=0x80. Second redirect to 0x300 during flush -> ignored, pc continues 0x84.
- Force pc to 0xFFFF_FFFC via jal, then advance -> pc=0x0. Assert rst_n=0 mid-flush -> outputs reset asynchronously before the next edge.
